display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//  Scans the double-buffered display_memory out to a HUB75 LED panel using binary-code modulation (BCM).
//  Owns the memory read port and the flip select.
//  Swaps buffers only at frame boundaries, on request from the frame writer.
//  Sits between display_memory and the panel pins.
// PARAMETERS
//  rows        8   panel rows; must be even; two row halves (a, a+rows/2) are driven together
//  columns     32  panel columns
//  color_bits  8   BCM planes per channel (1..8); uses the MSBs of each 8-bit channel
//  base_ticks  4   OE-on cycles for plane 0; plane b shows for base_ticks<<b cycles
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous, active-high reset
//  flip_req    in   1            pulse: writer finished a frame; sets pending flag
//  flip_ack    out  1            one-cycle pulse on the cycle flip toggles
//  frame_done  out  1            one-cycle pulse at every frame end
//  flip        out  1            buffer select to display_memory
//  rrow        out  $clog2(rows)    memory read row
//  rcol        out  $clog2(columns) memory read column
//  rdata       in   24           memory read data; R=[23:16] G=[15:8] B=[7:0]; valid 1 cycle after address
//  hub_rgb0    out  3            {R,G,B} plane bits, top half
//  hub_rgb1    out  3            {R,G,B} plane bits, bottom half
//  hub_clk     out  1            panel shift clock
//  hub_lat     out  1            panel latch
//  hub_oe      out  1            panel output enable, active low
//  hub_addr    out  $clog2(rows/2) panel row-pair address
// BEHAVIOUR
//  Reset values: flip=0, rrow/rcol=0, hub_rgb0/1=0, hub_clk=0, hub_lat=0, hub_oe=1, hub_addr=0, pulses=0, pending=0.
//  After reset the FSM is in RD_TOP with row pair a=0, plane b=0, column c=0.
//  Per column, 4 cycles:
//   - RD_TOP: rrow=a, rcol=c.
//   - RD_BOT: capture top bits, rrow=a+rows/2.
//   - SH_LO: drive hub_rgb0/1, hub_clk=0.
//   - SH_HI: hub_clk=1; c++; at c=columns-1 go to LATCH.
//  Captured bit for plane b: channel bit (8-color_bits+b) of each of R, G, B.
//  LATCH (1 cycle): hub_lat=1, hub_oe=1, hub_addr<=a.
//  SHOW: hub_oe=0 for exactly base_ticks<<b cycles.
//   - Then b++. After the last plane, a++. After the last row pair, frame end.
//   - hub_oe=1 in every state except SHOW (blank while shifting).
//  Plane cycles = 4*columns + 1 + (base_ticks<<b). Frame = sum over planes × rows/2.
//  Frame end (last SHOW cycle):
//   - frame_done pulses.
//   - If pending: flip toggles, flip_ack pulses, pending clears.
//   - Then a=b=c=0 and the FSM returns to RD_TOP.
//  flip_req arriving on the frame-end cycle is honoured at that same boundary.
//  Repeated flip_req while pending: no extra effect.
//  flip never changes mid-frame, so all reads in a frame come from one buffer.
//  rst mid-frame: all state back to reset values next edge; pending request dropped; flip returns to 0.
// CONFIGURATION
//  DISPLAY_SCAN_BRIGHTNESS_EN defined:
//   - Adds input brightness[7:0] (sampled at LATCH).
//   - In SHOW, hub_oe=0 only for the first ((base_ticks<<b)*brightness)>>8 cycles; SHOW length is unchanged.
//   - brightness=0 gives a dark panel; 255 is one cycle short of full on.
//  DISPLAY_SCAN_BRIGHTNESS_EN undefined: no port; full-length OE as above.
// STRUCTURE
//  display_defs.vh (shared include): channel slice constants (R/G/B lsb positions), pixel width 24, FSM state encodings.
//  Sub-module display_scan_bcm_timer:
//   - Loads base_ticks<<b (and the brightness threshold).
//   - Counts down and outputs show_active/show_done.
//  Top level: the FSM, the a/b/c counters, and the flip/pending logic.
// TESTING
//  Bench parameters: rows=4, columns=4, color_bits=2, base_ticks=2. Plane0=19 cycles, plane1=21, frame=80.
//  1 Reset: all outputs at reset values.
//    - First hub_clk rise 4 cycles after rst falls.
//    - hub_lat pulses at cycle 16; hub_oe low cycles 17-18.
//  2 Memory model holds pixel 0xC0_40_00 at (row0,col0), 0 elsewhere:
//    - Plane0 (bit6) first column: hub_rgb0=3'b110.
//    - Plane1 (bit7): hub_rgb0=3'b100.
//    - hub_rgb1=0 throughout.
//  3 flip_req pulse mid-frame:
//    - flip stays 0 until cycle 79 of the frame.
//    - Then flip=1, with flip_ack and frame_done pulsing on the same cycle.
//    - Next frame frame_done pulses without flip_ack.
//  4 flip_req on the frame-end cycle: flip toggles at that boundary. Two flip_req in one frame give a single toggle.
//  5 rst asserted during SHOW of row pair 1 with pending set:
//    - Next cycle hub_oe=1, flip=0, hub_addr=0.
//    - Frame restarts at RD_TOP, and no flip_ack follows.
//  6 With DISPLAY_SCAN_BRIGHTNESS_EN, brightness=128: plane1 hub_oe low 2 of 4 SHOW cycles; frame still 80 cycles.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// Shared scan-driver definitions: FSM states, 24-bit pixel layout and BCM plane-bit extraction.
package display_scan_driver_pkg;

   localparam int PIX_W = 24;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef enum logic [2:0] {
      ST_RD_TOP = 3'd0,
      ST_RD_BOT = 3'd1,
      ST_SH_LO  = 3'd2,
      ST_SH_HI  = 3'd3,
      ST_LATCH  = 3'd4,
      ST_SHOW   = 3'd5
   } scan_state_e;

   // {R,G,B} bit at position bit_idx of each 8-bit channel
   function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] px, input logic [2:0] bit_idx);
      logic [4:0] r_idx;
      logic [4:0] g_idx;
      logic [4:0] b_idx;
      r_idx = 5'(R_LSB) + {2'b00, bit_idx};
      g_idx = 5'(G_LSB) + {2'b00, bit_idx};
      b_idx = 5'(B_LSB) + {2'b00, bit_idx};
      return {px[r_idx], px[g_idx], px[b_idx]};
   endfunction

endpackage

// File: rtl/display_scan_bcm_timer.sv
// BCM show-window timer: loads base_ticks<<plane, counts down to the last SHOW cycle.
// With DISPLAY_SCAN_BRIGHTNESS_EN the OE window is cut to (ticks*brightness)>>8 cycles.
module display_scan_bcm_timer #(
   parameter int base_ticks = 4,
   parameter int BW         = 3,
   parameter int TW         = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          run_i,
   input  logic [BW-1:0] plane_i,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   input  logic [7:0]    brightness_i,
`endif
   output logic          show_active_o,
   output logic          show_done_o
);

   logic [TW-1:0] ticks;
   logic [TW-1:0] rem_q, rem_d;

   assign ticks = TW'(base_ticks) << plane_i;

   always_comb begin
      rem_d = rem_q;
      if (load_i) begin
         rem_d = ticks - TW'(1);
      end else if (run_i && (rem_q != '0)) begin
         rem_d = rem_q - TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign show_done_o = (rem_q == '0);

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   localparam int PW = TW + 8;
   logic [PW-1:0] scaled;
   logic [TW-1:0] lim_q, lim_d;

   // OE stays on while the remaining count is at or above ticks-threshold
   assign scaled = PW'(ticks) * PW'(brightness_i);

   always_comb begin
      lim_d = lim_q;
      if (load_i) begin
         lim_d = ticks - TW'(scaled >> 8);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lim_q <= '0;
      end else begin
         lim_q <= lim_d;
      end
   end

   assign show_active_o = (rem_q >= lim_q);
`else
   assign show_active_o = 1'b1;
`endif

endmodule

// File: rtl/display_scan_driver.sv
// HUB75 BCM scan driver: reads the double-buffered memory and shifts/latches/shows each plane.
// Optional DISPLAY_SCAN_BRIGHTNESS_EN adds a brightness input that trims the OE window.
module display_scan_driver
   import display_scan_driver_pkg::*;
#(
   parameter int rows       = 8,
   parameter int columns    = 32,
   parameter int color_bits = 8,
   parameter int base_ticks = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flip_req,
   output logic                       flip_ack,
   output logic                       frame_done,
   output logic                       flip,
   output logic [$clog2(rows)-1:0]    rrow,
   output logic [$clog2(columns)-1:0] rcol,
   input  logic [PIX_W-1:0]           rdata,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   input  logic [7:0]                 brightness,
`endif
   output logic [2:0]                 hub_rgb0,
   output logic [2:0]                 hub_rgb1,
   output logic                       hub_clk,
   output logic                       hub_lat,
   output logic                       hub_oe,
   output logic [$clog2(rows/2)-1:0]  hub_addr
);

   localparam int HALF = rows / 2;
   localparam int AW   = $clog2(HALF);
   localparam int RW   = $clog2(rows);
   localparam int CW   = $clog2(columns);
   localparam int BW   = (color_bits > 1) ? $clog2(color_bits) : 1;
   localparam int MAXT = base_ticks << (color_bits - 1);
   localparam int TW   = $clog2(MAXT + 1);

   scan_state_e   state_q, state_d;
   logic [AW-1:0] a_q, a_d;
   logic [BW-1:0] b_q, b_d;
   logic [CW-1:0] c_q, c_d;
   logic [2:0]    top_q, top_d;
   logic [2:0]    rgb0_q, rgb0_d;
   logic [2:0]    rgb1_q, rgb1_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          flip_q, flip_d;
   logic          pending_q, pending_d;
   logic          done_q, done_d;
   logic          ack_q, ack_d;

   logic          timer_load;
   logic          timer_run;
   logic          show_active;
   logic          show_done;
   logic [2:0]    bit_idx;

   assign bit_idx = 3'(8 - color_bits) + 3'(b_q);

   display_scan_bcm_timer #(
      .base_ticks (base_ticks),
      .BW         (BW),
      .TW         (TW)
   ) u_timer (
      .clk_i         (clk),
      .rst_i         (rst),
      .load_i        (timer_load),
      .run_i         (timer_run),
      .plane_i       (b_q),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      .brightness_i  (brightness),
`endif
      .show_active_o (show_active),
      .show_done_o   (show_done)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      top_d      = top_q;
      rgb0_d     = rgb0_q;
      rgb1_d     = rgb1_q;
      addr_d     = addr_q;
      flip_d     = flip_q;
      pending_d  = pending_q | flip_req;
      done_d     = 1'b0;
      ack_d      = 1'b0;
      timer_load = 1'b0;
      timer_run  = 1'b0;
      unique case (state_q)
         ST_RD_TOP: state_d = ST_RD_BOT;
         ST_RD_BOT: begin
            top_d   = plane_bits(rdata, bit_idx);
            state_d = ST_SH_LO;
         end
         ST_SH_LO: begin
            rgb0_d  = top_q;
            rgb1_d  = plane_bits(rdata, bit_idx);
            state_d = ST_SH_HI;
         end
         ST_SH_HI: begin
            if (c_q == CW'(columns - 1)) begin
               c_d     = '0;
               state_d = ST_LATCH;
            end else begin
               c_d     = c_q + CW'(1);
               state_d = ST_RD_TOP;
            end
         end
         ST_LATCH: begin
            addr_d     = a_q;
            timer_load = 1'b1;
            state_d    = ST_SHOW;
         end
         ST_SHOW: begin
            timer_run = 1'b1;
            if (show_done) begin
               state_d = ST_RD_TOP;
               if (b_q == BW'(color_bits - 1)) begin
                  b_d = '0;
                  if (a_q == AW'(HALF - 1)) begin
                     // frame boundary: the only place the buffer select may move
                     a_d       = '0;
                     done_d    = 1'b1;
                     pending_d = 1'b0;
                     if (pending_q || flip_req) begin
                        flip_d = ~flip_q;
                        ack_d  = 1'b1;
                     end
                  end else begin
                     a_d = a_q + AW'(1);
                  end
               end else begin
                  b_d = b_q + BW'(1);
               end
            end
         end
         default: state_d = ST_RD_TOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RD_TOP;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         top_q     <= '0;
         rgb0_q    <= '0;
         rgb1_q    <= '0;
         addr_q    <= '0;
         flip_q    <= 1'b0;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         top_q     <= top_d;
         rgb0_q    <= rgb0_d;
         rgb1_q    <= rgb1_d;
         addr_q    <= addr_d;
         flip_q    <= flip_d;
         pending_q <= pending_d;
         done_q    <= done_d;
         ack_q     <= ack_d;
      end
   end

   assign rrow       = (state_q == ST_RD_TOP) ? RW'(a_q) : (RW'(a_q) + RW'(HALF));
   assign rcol       = c_q;
   assign hub_clk    = (state_q == ST_SH_HI);
   assign hub_lat    = (state_q == ST_LATCH);
   assign hub_oe     = !((state_q == ST_SHOW) && show_active);
   assign hub_rgb0   = rgb0_q;
   assign hub_rgb1   = rgb1_q;
   assign hub_addr   = addr_q;
   assign flip       = flip_q;
   assign frame_done = done_q;
   assign flip_ack   = ack_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver against a cycle-position reference model.
`timescale 1ns/1ps
module tb_display_scan_driver;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int CB   = 2;
   localparam int BT   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       flip_req;
   logic       flip_ack;
   logic       frame_done;
   logic       flip;
   logic [1:0] rrow;
   logic [1:0] rcol;
   logic [23:0] rdata;
   logic [2:0] hub_rgb0;
   logic [2:0] hub_rgb1;
   logic       hub_clk;
   logic       hub_lat;
   logic       hub_oe;
   logic [0:0] hub_addr;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
   logic [7:0] brightness;
`endif

   logic [23:0] mem [0:1][0:ROWS-1][0:COLS-1];

   int n_cmp = 0;
   int n_err = 0;

   int t;
   bit m_flip, m_pend, m_done, m_ack;

   always #5 clk = ~clk;

   display_scan_driver #(
      .rows       (ROWS),
      .columns    (COLS),
      .color_bits (CB),
      .base_ticks (BT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flip_req   (flip_req),
      .flip_ack   (flip_ack),
      .frame_done (frame_done),
      .flip       (flip),
      .rrow       (rrow),
      .rcol       (rcol),
      .rdata      (rdata),
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .hub_rgb0   (hub_rgb0),
      .hub_rgb1   (hub_rgb1),
      .hub_clk    (hub_clk),
      .hub_lat    (hub_lat),
      .hub_oe     (hub_oe),
      .hub_addr   (hub_addr)
   );

   // synchronous memory: data for an address appears one cycle later
   always @(posedge clk) rdata <= mem[flip][rrow][rcol];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int plane_len(input int b);
      return 4 * COLS + 1 + (BT << b);
   endfunction

   function automatic int pair_len();
      int s = 0;
      for (int i = 0; i < CB; i++) s += plane_len(i);
      return s;
   endfunction

   function automatic int frame_len();
      return pair_len() * (ROWS / 2);
   endfunction

   function automatic logic [2:0] px_bits(input logic [23:0] p, input int bi);
      return {p[16 + bi], p[8 + bi], p[bi]};
   endfunction

   function automatic int oe_thr(input int ticks);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      return (ticks * int'(brightness)) >> 8;
`else
      return ticks;
`endif
   endfunction

   task automatic run_cycle(input bit r, input bit fr);
      int a, b, v, col, ph, bi;
      @(negedge clk);
      v = t % pair_len();
      a = t / pair_len();
      b = 0;
      while (v >= plane_len(b)) begin
         v -= plane_len(b);
         b++;
      end
      bi = 8 - CB + b;
      check_eq($sformatf("flip t=%0d", t), flip, m_flip);
      check_eq($sformatf("frame_done t=%0d", t), frame_done, m_done);
      check_eq($sformatf("flip_ack t=%0d", t), flip_ack, m_ack);
      if (v < 4 * COLS) begin
         col = v / 4;
         ph  = v % 4;
         check_eq($sformatf("hub_clk t=%0d", t), hub_clk, ph == 3);
         check_eq($sformatf("hub_lat t=%0d", t), hub_lat, 0);
         check_eq($sformatf("hub_oe t=%0d", t), hub_oe, 1);
         if (ph == 0) begin
            check_eq($sformatf("rrow_top t=%0d", t), rrow, a);
            check_eq($sformatf("rcol t=%0d", t), rcol, col);
         end
         if (ph == 1) check_eq($sformatf("rrow_bot t=%0d", t), rrow, a + ROWS / 2);
         if (ph == 3) begin
            check_eq($sformatf("rgb0 t=%0d", t), hub_rgb0, px_bits(mem[m_flip][a][col], bi));
            check_eq($sformatf("rgb1 t=%0d", t), hub_rgb1, px_bits(mem[m_flip][a + ROWS / 2][col], bi));
         end
      end else if (v == 4 * COLS) begin
         check_eq($sformatf("hub_lat t=%0d", t), hub_lat, 1);
         check_eq($sformatf("hub_oe t=%0d", t), hub_oe, 1);
         check_eq($sformatf("hub_clk t=%0d", t), hub_clk, 0);
      end else begin
         check_eq($sformatf("hub_oe_show t=%0d", t), hub_oe, !((v - 4 * COLS - 1) < oe_thr(BT << b)));
         check_eq($sformatf("hub_lat t=%0d", t), hub_lat, 0);
         check_eq($sformatf("hub_addr t=%0d", t), hub_addr, a);
      end
      rst      = r;
      flip_req = fr;
      m_done = 1'b0;
      m_ack  = 1'b0;
      if (r) begin
         t      = 0;
         m_flip = 1'b0;
         m_pend = 1'b0;
      end else begin
         if (fr) m_pend = 1'b1;
         if (t == frame_len() - 1) begin
            m_done = 1'b1;
            if (m_pend) begin
               m_flip = ~m_flip;
               m_ack  = 1'b1;
            end
            m_pend = 1'b0;
            t = 0;
         end else begin
            t++;
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      flip_req = 1'b0;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      brightness = 8'd128;
`endif
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[i][r][c] = 24'h0;
      mem[0][0][0] = 24'hC0_40_00;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst flip", flip, 0);
      check_eq("rst rrow", rrow, 0);
      check_eq("rst rcol", rcol, 0);
      check_eq("rst rgb0", hub_rgb0, 0);
      check_eq("rst rgb1", hub_rgb1, 0);
      check_eq("rst hub_clk", hub_clk, 0);
      check_eq("rst hub_lat", hub_lat, 0);
      check_eq("rst hub_oe", hub_oe, 1);
      check_eq("rst hub_addr", hub_addr, 0);
      check_eq("rst frame_done", frame_done, 0);
      check_eq("rst flip_ack", flip_ack, 0);

      t = 0; m_flip = 0; m_pend = 0; m_done = 0; m_ack = 0;
      run_cycle(1'b1, 1'b0);

      // directed: double request, idle frame, frame-end request, reset in pair-1 SHOW
      for (int k = 0; k < 550; k++) begin
         run_cycle(k == 377, k inside {30, 50, 239, 250, 340});
         if (k == 3)   check_eq("p0 col0 rgb0", hub_rgb0, 3'b110);
         if (k == 22)  check_eq("p1 col0 rgb0", hub_rgb0, 3'b100);
         if (k == 378) begin
            check_eq("post-rst hub_addr", hub_addr, 0);
            check_eq("post-rst hub_oe", hub_oe, 1);
            check_eq("post-rst flip", flip, 0);
         end
      end

      // randomized: fresh buffers, random flip requests and resets
      run_cycle(1'b1, 1'b0);
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[i][r][c] = 24'($urandom);
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      for (int k = 0; k < 3000; k++) begin
         run_cycle($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
